ttl_nand_bist: RTL
==================

// Module: ttl_nand_bist
// PURPOSE
//   Synchronous built-in self-test sequencer for a BLOCKS x WIDTH_IN-input NAND gate array.
//   - Drives every input pattern exhaustively onto the gate array's A_2D bus.
//   - Waits a programmable settle time for each pattern, then samples the gate's Y.
//   - Compares Y against ~&(slice) for each block and reports the pass/fail result.
//   Sits between a board-level test controller and an asynchronous 7420-style gate model.
// PARAMETERS
//   BLOCKS         2   number of NAND gates under test
//   WIDTH_IN       4   inputs per gate; pattern width PW = BLOCKS*WIDTH_IN (PW <= 16)
//   SETTLE_CYCLES  2   Clk cycles waited after applying a pattern, before sampling (>= 1)
//   FAIL_W         8   width of the failure counter
// PORTS
//   Clk           input   1       rising-edge clock
//   Clear         input   1       synchronous, active-high reset
//   Start         input   1       single-cycle run request, honoured only in IDLE
//   Y_in          input   BLOCKS  outputs of the gate array under test
//   A_2D          output  PW      pattern driven to the gate array; block b = A_2D[b*WIDTH_IN +: WIDTH_IN]
//   Busy          output  1       high while a run is in progress
//   Done          output  1       high in DONE; held until the next accepted Start or Clear
//   Pass          output  1       valid when Done: 1 iff Fail_Count == 0
//   Fail_Count    output  FAIL_W  number of failing patterns; saturates at all-ones
//   Fail_Pattern  output  PW      first failing pattern; 0 when there is none
// BEHAVIOUR
//   - Reset: Clear=1 at a Clk edge forces the state to IDLE and all outputs to 0.
//     This holds in any state, including mid-run; Clear has priority over Start.
//   - FSM states: IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | DONE); DONE -> APPLY on Start.
//   - IDLE/DONE + Start:
//     - Pattern counter P <= 0, Fail_Count <= 0 and Fail_Pattern <= 0.
//     - Busy <= 1 and Done <= 0; go to APPLY.
//   - Start is ignored in APPLY, SETTLE and CHECK.
//   - APPLY (1 cycle): A_2D <= P; the settle counter is loaded with SETTLE_CYCLES-1.
//   - SETTLE (SETTLE_CYCLES cycles): A_2D is held stable; the counter decrements to 0.
//   - CHECK (1 cycle):
//     - Expected E[b] = ~&P[b-slice].
//     - A mismatch is Y_in != E, i.e. any block wrong; a pattern counts at most once.
//     - On a mismatch: Fail_Count increments (saturating at all-ones).
//       If Fail_Count was 0, Fail_Pattern <= P.
//     - If P == all-ones: go to DONE. Otherwise P <= P+1 and go to APPLY.
//   - DONE:
//     - Busy = 0 and Done = 1; Pass = (Fail_Count == 0).
//     - A_2D keeps the last pattern driven.
//   - Timing: each pattern takes SETTLE_CYCLES+2 cycles.
//     Done rises 2^PW*(SETTLE_CYCLES+2)+1 edges after the edge that accepted Start.
//   - A_2D changes only on the APPLY edge, so the gate input never glitches mid-settle.
// CONFIGURATION
//   - TTL_NAND_BIST_STOP_ON_FAIL_EN defined:
//     - The first mismatch in CHECK goes directly to DONE.
//     - Fail_Count = 1, Pass = 0, Fail_Pattern = the failing P.
//   - Not defined: the sweep always covers all 2^PW patterns.
// STRUCTURE
//   - Shared header ttl_bist_defs.vh:
//     - FSM state encodings (IDLE, APPLY, SETTLE, CHECK, DONE; 3 bits).
//     - A saturating-increment function shared with future BIST blocks.
//   - One sub-module, ttl_nand_bist_expect: purely combinational P -> E[BLOCKS-1:0].
//     It is reused to build expected values for 7410/7430-family BIST variants.
// TESTING  (BLOCKS=2, WIDTH_IN=4, SETTLE_CYCLES=2, FAIL_W=8, ideal delayed NAND model)
//   - Fault-free gate, Start pulse:
//     Done=1 at edge 1025 after Start, Pass=1, Fail_Count=0, Fail_Pattern=0.
//   - Y_in[0] stuck at 1:
//     Fail_Count=16, Fail_Pattern=8'h0F, Pass=0.
//   - Y_in stuck at 2'b00, FAIL_W=3:
//     Fail_Count saturates at 3'b111, Fail_Pattern=8'h00.
//   - Clear asserted at pattern 0x40 in SETTLE:
//     Next edge gives IDLE with all outputs 0; a fresh Start completes with Pass=1.
//   - Start re-pulsed during SETTLE:
//     Ignored; completion time and results are unchanged.
//   - TTL_NAND_BIST_STOP_ON_FAIL_EN, Y_in[0] stuck at 1:
//     Done after CHECK of 0x0F; Fail_Count=1, Fail_Pattern=8'h0F, A_2D=8'h0F.

Source files
------------

// File: rtl/ttl_nand_bist_pkg.sv
// Shared definitions for the NAND-array BIST: FSM state encoding and a
// saturating increment reused by other BIST counters (widths up to 16 bits).
package ttl_nand_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned MAX_PW    = 16;
  localparam int unsigned MAX_CNT_W = 16;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input int unsigned w);
    logic [15:0] mx;
    mx = 16'((32'd1 << w) - 32'd1);
    return (v >= mx) ? mx : v + 16'd1;
  endfunction

endpackage

// File: rtl/ttl_nand_bist_if.sv
// Test-controller <-> BIST sequencer signal bundle; the gate array's Y and A
// buses travel here too. slave = sequencer side, master = controller/board side.
interface ttl_nand_bist_if #(
  parameter int BLOCKS   = 2,
  parameter int WIDTH_IN = 4,
  parameter int FAIL_W   = 8
);
  localparam int PW = BLOCKS * WIDTH_IN;

  logic              Start;
  logic [BLOCKS-1:0] Y_in;
  logic [PW-1:0]     A_2D;
  logic              Busy;
  logic              Done;
  logic              Pass;
  logic [FAIL_W-1:0] Fail_Count;
  logic [PW-1:0]     Fail_Pattern;

  modport master (
    output Start, Y_in,
    input  A_2D, Busy, Done, Pass, Fail_Count, Fail_Pattern
  );

  modport slave (
    input  Start, Y_in,
    output A_2D, Busy, Done, Pass, Fail_Count, Fail_Pattern
  );

endinterface

// File: rtl/ttl_nand_bist_expect.sv
// Combinational golden response of a BLOCKS x WIDTH_IN NAND array for one pattern.
module ttl_nand_bist_expect
  import ttl_nand_bist_pkg::*;
#(
  parameter int BLOCKS   = 2,
  parameter int WIDTH_IN = 4
) (
  input  logic [BLOCKS*WIDTH_IN-1:0] pattern,
  output logic [BLOCKS-1:0]          expect_y
);

  for (genvar b = 0; b < BLOCKS; b++) begin : g_blk
    assign expect_y[b] = ~&pattern[b*WIDTH_IN +: WIDTH_IN];
  end

endmodule

// File: rtl/ttl_nand_bist.sv
// Exhaustive NAND-array BIST sequencer: IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | DONE).
// Defining TTL_NAND_BIST_STOP_ON_FAIL_EN ends the sweep at the first failing pattern.
module ttl_nand_bist
  import ttl_nand_bist_pkg::*;
#(
  parameter int BLOCKS        = 2,
  parameter int WIDTH_IN      = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int FAIL_W        = 8
) (
  input logic             Clk,
  input logic             Clear,
  ttl_nand_bist_if.slave  bus
);

  localparam int PW = BLOCKS * WIDTH_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  state_t            state, state_n;
  logic [PW-1:0]     p, p_n;
  logic [PW-1:0]     a_2d, a_2d_n;
  logic [PW-1:0]     fail_pat, fail_pat_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FAIL_W-1:0] fail_cnt, fail_cnt_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic [BLOCKS-1:0] expect_y;
  logic              mismatch;
  logic              last;

  ttl_nand_bist_expect #(
    .BLOCKS   (BLOCKS),
    .WIDTH_IN (WIDTH_IN)
  ) u_expect (
    .pattern  (p),
    .expect_y (expect_y)
  );

  assign mismatch = (bus.Y_in != expect_y);
  assign last     = &p;

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state    <= ST_IDLE;
      p        <= '0;
      a_2d     <= '0;
      fail_pat <= '0;
      cnt      <= '0;
      fail_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      p        <= p_n;
      a_2d     <= a_2d_n;
      fail_pat <= fail_pat_n;
      cnt      <= cnt_n;
      fail_cnt <= fail_cnt_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    p_n        = p;
    a_2d_n     = a_2d;
    fail_pat_n = fail_pat;
    cnt_n      = cnt;
    fail_cnt_n = fail_cnt;
    busy_n     = busy;
    done_n     = done;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          p_n        = '0;
          fail_cnt_n = '0;
          fail_pat_n = '0;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          state_n    = ST_APPLY;
        end else if (state == ST_DONE) begin
          // Flags follow the state by one edge so Busy stays high until Done rises.
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end
      ST_APPLY: begin
        a_2d_n  = p;
        cnt_n   = SETTLE_LOAD;
        state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) state_n = ST_CHECK;
        else           cnt_n   = cnt - 1'b1;
      end
      ST_CHECK: begin
        if (mismatch) begin
          fail_cnt_n = FAIL_W'(sat_inc(16'(fail_cnt), FAIL_W));
          if (fail_cnt == '0) fail_pat_n = p;
        end
`ifdef TTL_NAND_BIST_STOP_ON_FAIL_EN
        if (mismatch || last) begin
`else
        if (last) begin
`endif
          state_n = ST_DONE;
        end else begin
          p_n     = p + 1'b1;
          state_n = ST_APPLY;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.A_2D         = a_2d;
  assign bus.Busy         = busy;
  assign bus.Done         = done;
  assign bus.Pass         = done & (fail_cnt == '0);
  assign bus.Fail_Count   = fail_cnt;
  assign bus.Fail_Pattern = fail_pat;

endmodule
